// File: rtl/led_latch_rx.sv
`default_nettype none
// ============================================================================
//  Module   : led_latch_rx
//  Purpose  : Serial receiver/decoder for the LED-driver latch protocol
//             (SCLK/SIN/LAT, 769-bit latch, bit 768 selects control vs
//             grayscale). Models one driver of a two-deep daisy chain: a
//             shift register with SOUT pass-through, a control latch and a
//             grayscale latch, all sampled in the CLK_10M domain.
//  Ports    : CLK_10M, nReset (sync, active-low)
//             SCLK, SIN, LAT        - serial interface inputs (asynchronous)
//             SOUT                  - daisy-chain output, registered sr[768]
//             gs_rd_addr            - channel index 0..47 (led*3 + color)
//             gs_rd_data/dc_rd_data - registered read of addressed channel
//             mc, bc, fc            - control-latch fields
//             ctrl_valid            - sticky, first accepted control latch
//             latch_stb/latch_sel   - accepted-latch pulse and its select bit
//             gs_count              - accepted grayscale latches (wrapping)
//             bit_err               - rejected-latch pulse
//  Options  : LED_RX_BITCOUNT_CHECK_EN - reject a latch whose SCLK count
//             differs from EXPECT_BITS (latch untouched, bit_err pulses).
//  Revision : 1.0 - initial release
// ============================================================================
module led_latch_rx #(
    parameter int LATCH_SIZE  = 769,
    parameter int EXPECT_BITS = 1538,
    parameter int CNT_W       = 12
) (
    input  logic        CLK_10M,
    input  logic        nReset,
    input  logic        SCLK,
    input  logic        SIN,
    input  logic        LAT,
    output logic        SOUT,
    input  logic [5:0]  gs_rd_addr,
    output logic [15:0] gs_rd_data,
    output logic [6:0]  dc_rd_data,
    output logic [8:0]  mc,
    output logic [20:0] bc,
    output logic [4:0]  fc,
    output logic        ctrl_valid,
    output logic        latch_stb,
    output logic        latch_sel,
    output logic [15:0] gs_count,
    output logic        bit_err
);

    localparam int              c_num_ch    = 48;
    localparam logic [CNT_W-1:0] c_expect   = CNT_W'(EXPECT_BITS);
    localparam logic [1:0]      c_st_idle   = 2'd0;
    localparam logic [1:0]      c_st_shift  = 2'd1;
    localparam logic [1:0]      c_st_decode = 2'd2;

`ifdef LED_RX_BITCOUNT_CHECK_EN
    localparam logic c_cnt_check = 1'b1;
`else
    localparam logic c_cnt_check = 1'b0;
`endif

    // Input synchronisers. SIN only needs two stages; the third SCLK/LAT
    // stage exists purely for edge detection against stage 2.
    logic [2:0] r_sclk_sync;
    logic [2:0] r_lat_sync;
    logic [1:0] r_sin_sync;

    logic [LATCH_SIZE-1:0] r_sr;
    logic [CNT_W-1:0]      r_bit_cnt;
    logic [1:0]            r_state;
    logic                  r_sout;
    logic [15:0]           r_gs [c_num_ch];
    logic [6:0]            r_dc [c_num_ch];
    logic [15:0]           r_gs_rd_data;
    logic [6:0]            r_dc_rd_data;
    logic [8:0]            r_mc;
    logic [20:0]           r_bc;
    logic [4:0]            r_fc;
    logic                  r_ctrl_valid;
    logic                  r_latch_stb;
    logic                  r_latch_sel;
    logic [15:0]           r_gs_count;
    logic                  r_bit_err;

    logic                  w_sclk_rise;
    logic                  w_lat_rise;
    logic [LATCH_SIZE-1:0] w_sr_next;
    logic [CNT_W-1:0]      w_cnt_next;
    logic                  w_cnt_ok;
    logic                  w_sel;
    logic [1:0]            w_state_next;
    logic                  w_decode;
    logic                  w_accept;
    logic                  w_reject;
    logic                  w_cnt_clr;

    assign w_sclk_rise = r_sclk_sync[1] & ~r_sclk_sync[2];
    assign w_lat_rise  = r_lat_sync[1]  & ~r_lat_sync[2];

    // Post-shift view of the register: a LAT edge coincident with the last
    // SCLK edge must decode the freshly shifted bit, so decode reads these.
    assign w_sr_next  = w_sclk_rise ? {r_sr[LATCH_SIZE-2:0], r_sin_sync[1]} : r_sr;
    assign w_cnt_next = (w_sclk_rise && (r_bit_cnt != '1)) ? r_bit_cnt + 1'b1 : r_bit_cnt;
    assign w_cnt_ok   = !c_cnt_check || (w_cnt_next == c_expect);
    assign w_sel      = w_sr_next[LATCH_SIZE-1];

    // ---------------- FSM: state register ----------------
    always_ff @(posedge CLK_10M) begin
        if (!nReset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_lat_rise) begin
                    w_state_next = c_st_decode;
                end else if (w_sclk_rise) begin
                    w_state_next = c_st_shift;
                end
            end
            c_st_shift: begin
                if (w_lat_rise) begin
                    w_state_next = c_st_decode;
                end
            end
            c_st_decode: w_state_next = c_st_idle;
            default:     w_state_next = c_st_idle;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // Latch registers load on the edge that enters DECODE, so latch_stb is
    // high during the DECODE cycle itself (3 cycles after the LAT pin edge).
    always_comb begin
        w_decode  = (r_state != c_st_decode) && w_lat_rise;
        w_accept  = w_decode && w_cnt_ok;
        w_reject  = w_decode && !w_cnt_ok;
        w_cnt_clr = (r_state == c_st_decode);
    end

    // ---------------- datapath ----------------
    always_ff @(posedge CLK_10M) begin
        if (!nReset) begin
            r_sclk_sync  <= '0;
            r_lat_sync   <= '0;
            r_sin_sync   <= '0;
            r_sr         <= '0;
            r_bit_cnt    <= '0;
            r_sout       <= 1'b0;
            r_mc         <= '0;
            r_bc         <= '0;
            r_fc         <= '0;
            r_ctrl_valid <= 1'b0;
            r_latch_stb  <= 1'b0;
            r_latch_sel  <= 1'b0;
            r_gs_count   <= '0;
            r_bit_err    <= 1'b0;
            r_gs_rd_data <= '0;
            r_dc_rd_data <= '0;
            for (int i = 0; i < c_num_ch; i++) begin
                r_gs[i] <= '0;
                r_dc[i] <= '0;
            end
        end else begin
            r_sclk_sync <= {r_sclk_sync[1:0], SCLK};
            r_lat_sync  <= {r_lat_sync[1:0], LAT};
            r_sin_sync  <= {r_sin_sync[0], SIN};

            r_sr <= w_sr_next;
            if (w_sclk_rise) begin
                r_sout <= r_sr[LATCH_SIZE-1];
            end
            r_bit_cnt <= w_cnt_clr ? '0 : w_cnt_next;

            r_latch_stb <= w_accept;
            r_bit_err   <= w_reject;

            if (w_accept) begin
                r_latch_sel <= w_sel;
                if (w_sel) begin
                    for (int i = 0; i < c_num_ch; i++) begin
                        r_dc[i] <= w_sr_next[i*7 +: 7];
                    end
                    r_mc         <= w_sr_next[344:336];
                    r_bc         <= w_sr_next[365:345];
                    r_fc         <= w_sr_next[370:366];
                    r_ctrl_valid <= 1'b1;
                end else begin
                    for (int i = 0; i < c_num_ch; i++) begin
                        r_gs[i] <= w_sr_next[i*16 +: 16];
                    end
                    r_gs_count <= r_gs_count + 16'd1;
                end
            end

            // Registered read: an update on this edge is seen one cycle later.
            if (gs_rd_addr < 6'(c_num_ch)) begin
                r_gs_rd_data <= r_gs[gs_rd_addr];
                r_dc_rd_data <= r_dc[gs_rd_addr];
            end else begin
                r_gs_rd_data <= '0;
                r_dc_rd_data <= '0;
            end
        end
    end

    assign SOUT       = r_sout;
    assign gs_rd_data = r_gs_rd_data;
    assign dc_rd_data = r_dc_rd_data;
    assign mc         = r_mc;
    assign bc         = r_bc;
    assign fc         = r_fc;
    assign ctrl_valid = r_ctrl_valid;
    assign latch_stb  = r_latch_stb;
    assign latch_sel  = r_latch_sel;
    assign gs_count   = r_gs_count;
    assign bit_err    = r_bit_err;

endmodule
`default_nettype wire
